// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the state encoding, the minimum legal ratio and the ratio clamp.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] MIN_DIV = 32'd2;

    // Ratios below MIN_DIV cannot produce both a high and a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        logic [31:0] res;
        if (div < MIN_DIV) begin
            res = MIN_DIV;
        end else begin
            res = div;
        end
        return res;
    endfunction

endpackage

// File: rtl/clkdiv_gen.sv
// Programmable integer clock divider with glitch-free start/stop.
// Y is taken straight from a flop; ratio and enable changes land only on period boundaries.
module clkdiv_gen
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [CNT_W-1:0] DIV,
    input  logic             DIV_REQ,
    output logic             DIV_ACK,
    output logic             Y,
    output logic             TICK,
    output logic             RUNNING
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] n_act_r;
    logic [CNT_W-1:0] n_act_nxt_s;
    logic             y_r;
    logic             y_nxt_s;
    logic             tick_r;
    logic             tick_nxt_s;
    logic             ack_r;
    logic             ack_nxt_s;
    logic             running_r;
    logic             running_nxt_s;

    logic [CNT_W-1:0] div_clamped_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] high_len_s;
    logic             pb_s;

    assign div_clamped_s = CNT_W'(clamp_div(32'(DIV)));
    assign cnt_inc_s     = cnt_r + CNT_ONE;
    // High phase is ceil(N/2) cycles, so odd ratios favour the high side.
    assign high_len_s    = n_act_r - (n_act_r >> 1);
    assign pb_s          = (cnt_r == (n_act_r - CNT_ONE));

    // Next-state, counter, ratio and registered-output decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        n_act_nxt_s = n_act_r;
        y_nxt_s     = 1'b0;
        tick_nxt_s  = 1'b0;
        ack_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (DIV_REQ) begin
                    n_act_nxt_s = div_clamped_s;
                    ack_nxt_s   = 1'b1;
                end else begin
                    n_act_nxt_s = n_act_r;
                end
                if (EN) begin
                    state_nxt_s = RUN;
                    y_nxt_s     = 1'b1;
                    tick_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN, DRAIN: begin
                if (pb_s) begin
                    // Wrap edge: the only point where ratio and run/stop may change.
                    cnt_nxt_s = CNT_ZERO;
                    if (DIV_REQ) begin
                        n_act_nxt_s = div_clamped_s;
                        ack_nxt_s   = 1'b1;
                    end else begin
                        n_act_nxt_s = n_act_r;
                    end
                    if (EN) begin
                        state_nxt_s = RUN;
                        y_nxt_s     = 1'b1;
                        tick_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                    y_nxt_s   = (cnt_inc_s < high_len_s);
                    if ((state_r == RUN) && !EN) begin
                        state_nxt_s = DRAIN;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
        running_nxt_s = (state_nxt_s != IDLE);
    end

    // State, counter, active ratio and all output flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            n_act_r   <= CNT_W'(DEFAULT_DIV);
            y_r       <= 1'b0;
            tick_r    <= 1'b0;
            ack_r     <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            n_act_r   <= n_act_nxt_s;
            y_r       <= y_nxt_s;
            tick_r    <= tick_nxt_s;
            ack_r     <= ack_nxt_s;
            running_r <= running_nxt_s;
        end
    end

    assign Y       = y_r;
    assign TICK    = tick_r;
    assign DIV_ACK = ack_r;
    assign RUNNING = running_r;

endmodule

// File: tb/tb_clkdiv_gen.sv
// Self-checking bench for clkdiv_gen: directed pattern checks plus randomized
// traffic compared every cycle against a period-level behavioural model.
module tb_clkdiv_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div;
    logic       div_req;
    logic       div_ack;
    logic       y;
    logic       tick;
    logic       running;

    int checks = 0;
    int errors = 0;

    // Model: a period of length per is ceil(per/2) ones followed by zeros.
    int m_active;
    int m_pos;
    int m_per;
    int m_n;
    int exp_y, exp_tick, exp_run, exp_ack;

    logic [15:0] yv, tv, rv;

    clkdiv_gen #(.CNT_W(8), .DEFAULT_DIV(2)) dut (
        .CLK(clk), .RST(rst), .EN(en), .DIV(div), .DIV_REQ(div_req),
        .DIV_ACK(div_ack), .Y(y), .TICK(tick), .RUNNING(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_per = 2; m_n = 2;
        exp_y = 0; exp_tick = 0; exp_run = 0; exp_ack = 0;
    endtask

    function automatic int clampm(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_edge();
        exp_ack = 0;
        exp_tick = 0;
        if (m_active == 0) begin
            if (div_req) begin m_n = clampm(int'(div)); exp_ack = 1; end
            if (en) begin m_active = 1; m_per = m_n; m_pos = 0; exp_tick = 1; end
        end else if (m_pos == m_per - 1) begin
            if (div_req) begin m_n = clampm(int'(div)); exp_ack = 1; end
            if (en) begin m_per = m_n; m_pos = 0; exp_tick = 1; end
            else m_active = 0;
        end else begin
            m_pos++;
        end
        exp_run = m_active;
        exp_y = (m_active != 0 && m_pos < (m_per + 1) / 2) ? 1 : 0;
    endtask

    // One clock: model steps on the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("Y", int'(y), exp_y);
        chk("TICK", int'(tick), exp_tick);
        chk("RUNNING", int'(running), exp_run);
        chk("DIV_ACK", int'(div_ack), exp_ack);
    endtask

    task automatic clear_rec();
        yv = {15'd0, y}; tv = {15'd0, tick}; rv = {15'd0, running};
    endtask

    task automatic rec(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            yv = {yv[14:0], y}; tv = {tv[14:0], tick}; rv = {rv[14:0], running};
        end
    endtask

    task automatic wait_ack(input int bound);
        int seen;
        seen = 0;
        for (int i = 0; i < bound && seen == 0; i++) begin
            cycle();
            if (div_ack) seen = 1;
        end
        div_req = 1'b0;
        chk("ack_timeout", seen, 1);
    endtask

    task automatic wait_idle(input int bound);
        int seen;
        seen = 0;
        for (int i = 0; i < bound && seen == 0; i++) begin
            cycle();
            if (!running) seen = 1;
        end
        chk("idle_timeout", seen, 1);
    endtask

    task automatic set_ratio_idle(input logic [7:0] d);
        div = d; div_req = 1'b1;
        cycle();
        chk("idle_ack", int'(div_ack), 1);
        div_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; div = 8'd0; div_req = 1'b0;
        model_reset();
        #1;
        chk("rst_Y", int'(y), 0);
        chk("rst_TICK", int'(tick), 0);
        chk("rst_RUNNING", int'(running), 0);
        chk("rst_DIV_ACK", int'(div_ack), 0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        cycle();

        // T1: N=4 gives 1100, TICK on each rising edge
        set_ratio_idle(8'd4);
        en = 1'b1;
        cycle();
        chk("T1_first_Y", int'(y), 1);
        clear_rec(); rec(7);
        chk("T1_Y", int'(yv[7:0]), 8'b11001100);
        chk("T1_TICK", int'(tv[7:0]), 8'b10001000);
        chk("T1_RUN", int'(rv[7:0]), 8'b11111111);

        // T2: N=5 then N=2 while running
        div = 8'd5; div_req = 1'b1;
        wait_ack(20);
        clear_rec(); rec(9);
        chk("T2_Y5", int'(yv[9:0]), 10'b1110011100);
        div = 8'd2; div_req = 1'b1;
        wait_ack(20);
        clear_rec(); rec(7);
        chk("T2_Y2", int'(yv[7:0]), 8'b10101010);

        // T3: N=6, EN dropped at cnt=1, period completes then stops
        div = 8'd6; div_req = 1'b1;
        wait_ack(20);
        clear_rec(); rec(1);
        en = 1'b0;
        rec(6);
        chk("T3_Y", int'(yv[7:0]), 8'b11100000);
        chk("T3_RUN", int'(rv[7:0]), 8'b11111100);

        // T4: N=4 running, DIV=8 request at cnt=1 lands on the wrap edge
        set_ratio_idle(8'd4);
        en = 1'b1;
        cycle(); cycle();
        div = 8'd8; div_req = 1'b1;
        cycle(); chk("T4_ack_cnt2", int'(div_ack), 0);
        cycle(); chk("T4_ack_cnt3", int'(div_ack), 0);
        cycle(); chk("T4_ack_wrap", int'(div_ack), 1);
        div_req = 1'b0;
        clear_rec(); rec(7);
        chk("T4_Y", int'(yv[7:0]), 8'b11110000);

        // T5: DIV=0 in IDLE clamps to 2
        en = 1'b0;
        wait_idle(40);
        set_ratio_idle(8'd0);
        en = 1'b1;
        cycle();
        clear_rec(); rec(7);
        chk("T5_Y", int'(yv[7:0]), 8'b10101010);

        // T6: async reset in a high phase, then restart at DEFAULT_DIV
        en = 1'b0;
        wait_idle(40);
        set_ratio_idle(8'd4);
        en = 1'b1;
        cycle(); cycle();
        chk("T6_pre_Y", int'(y), 1);
        #1 rst = 1'b1;
        #1;
        chk("T6_Y", int'(y), 0);
        chk("T6_TICK", int'(tick), 0);
        chk("T6_RUNNING", int'(running), 0);
        model_reset();
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        cycle();
        clear_rec(); rec(5);
        chk("T6_restart_Y", int'(yv[5:0]), 6'b101010);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if (!div_req && $urandom_range(0, 29) == 0) begin
                div_req = 1'b1;
                if ($urandom_range(0, 9) == 0) div = 8'($urandom_range(0, 255));
                else div = 8'($urandom_range(0, 9));
            end else if (div_req && $urandom_range(0, 49) == 0) begin
                div_req = 1'b0;
            end
            cycle();
            if (div_ack) div_req = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
